mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: width of data, weight and result words.
REQ-002 SHALL have parameter INPUT_LENGTH, default 8: input words per vector, i.e. weights per neuron.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(INPUT_LENGTH+1): weight-memory address width.
REQ-004 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port valid_i  input  1  upstream input word valid.
REQ-007 SHALL have port ready_o  output  1  sequencer accepts an input word.
REQ-008 SHALL have port data_i  input  WORD_SIZE  signed input word.
REQ-009 SHALL have port mem_addr_o  output  ADDR_WIDTH  weight-ROM address; addresses 0..INPUT_LENGTH-1 are weights, address INPUT_LENGTH is the bias.
REQ-010 SHALL have port mem_data_i  input  WORD_SIZE  ROM word, valid one cycle after its address.
REQ-011 SHALL have port lu_mem_o  output  WORD_SIZE  drives logical_unit mem_i.
REQ-012 SHALL have port lu_data_o  output  WORD_SIZE  drives logical_unit data_i.
REQ-013 SHALL have port lu_sum_en_o  output  1  drives logical_unit sum_en.
REQ-014 SHALL have port lu_add_bias_o  output  1  drives logical_unit add_bias.
REQ-015 SHALL have port lu_clear_o  output  1  drives logical_unit reset_i.
REQ-016 SHALL have port lu_result_i  input  WORD_SIZE  logical_unit data_o.
REQ-017 SHALL have port valid_o  output  1  result valid.
REQ-018 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-019 SHALL have port data_o  output  WORD_SIZE  result word.

Function
REQ-020 SHALL implement states CLEAR, ACCUM, BIAS, BIAS_APPLY and OUTPUT, with a counter cnt of ADDR_WIDTH bits.
REQ-021 CLEAR SHALL assert lu_clear_o for exactly one cycle, set cnt=0 and go to ACCUM.
REQ-022 ACCUM SHALL drive ready_o=1 and mem_addr_o=cnt; a beat is accepted when valid_i&&ready_o, and each accepted beat SHALL increment cnt.
REQ-023 Each accepted beat SHALL register data_i plus an issue flag; in the next cycle lu_sum_en_o=1, lu_data_o=registered word and lu_mem_o=mem_data_i.
REQ-024 A cycle with valid_i=0 SHALL produce lu_sum_en_o=0 in the following cycle; the order of accumulated terms SHALL be unaffected.
REQ-025 Acceptance of beat INPUT_LENGTH-1 SHALL move to BIAS.
REQ-026 BIAS SHALL drive ready_o=0 and mem_addr_o=INPUT_LENGTH (the final data sum_en fires here), then move to BIAS_APPLY.
REQ-027 BIAS_APPLY SHALL drive lu_sum_en_o=1, lu_add_bias_o=1 and lu_mem_o=mem_data_i for one cycle, then move to OUTPUT.
REQ-028 OUTPUT SHALL drive valid_o=1 and data_o=lu_result_i with lu_sum_en_o=0; data_o SHALL be held stable while ready_i=0.
REQ-029 valid_o&&ready_i SHALL move to CLEAR; throughput SHALL be one vector per INPUT_LENGTH+4 cycles with no stalls.
REQ-030 lu_add_bias_o SHALL be 0 in every state except BIAS_APPLY; ready_o SHALL be 0 in every state except ACCUM.
REQ-031 Latency SHALL be valid_o rising 3 cycles after the edge that accepts the last beat.

Reset
REQ-032 reset_i high SHALL asynchronously force state=CLEAR, cnt=0 and the issue flag to 0.
REQ-033 While reset_i is high, outputs SHALL be: ready_o=0, valid_o=0, lu_sum_en_o=0, lu_add_bias_o=0, mem_addr_o=0, data_o=0, lu_mem_o=0, lu_data_o=0, lu_clear_o=1.
REQ-034 Reset in any state, including mid-vector, SHALL discard the partial sum; the first cycle after release SHALL be CLEAR.

Configuration
REQ-035 Macro MAC_SEQUENCER_BIAS_EN defined: SHALL behave as REQ-025..REQ-027.
REQ-036 Macro MAC_SEQUENCER_BIAS_EN undefined: BIAS and BIAS_APPLY SHALL be absent, lu_add_bias_o SHALL be tied 0, and the last beat SHALL go to a one-cycle DRAIN state (ready_o=0, final sum_en), then to OUTPUT, giving a latency of 2 cycles.

Verification
(All scenarios use the logical_unit model with INPUT_LENGTH=4, WORD_SIZE=16, INT_BITS=4.)
REQ-037 Bias enabled: four back-to-back beats of 0x1000, weights 0x1000, bias 0x0800 -> mem_addr_o sequence 0,1,2,3,4; four sum_en pulses then one add_bias pulse; valid_o 3 cycles after the last accept; data_o=0x4800.
REQ-038 valid_i low for 2 cycles between beats 1 and 2 -> lu_sum_en_o gaps of 2 cycles; data_o still 0x4800.
REQ-039 ready_i low for 5 cycles in OUTPUT -> valid_o and data_o=0x4800 held; ready_o=0; lu_clear_o pulses exactly once after the handshake.
REQ-040 reset_i pulsed after 2 beats, then a new vector of 0x2000 words -> data_o=0x8800 saturated to 0x7FFF; no residue from the aborted vector.
REQ-041 Macro undefined, same stimulus as REQ-037 -> no add_bias pulse; valid_o 2 cycles after the last accept; data_o=0x4000.

Source files
------------

// File: rtl/mac_sequencer.sv
// Sequencer feeding a multiply-accumulate logical unit: streams a vector against ROM weights, then emits the result.
// Define MAC_SEQUENCER_BIAS_EN to add a bias word (ROM address INPUT_LENGTH) before the result is presented.
module mac_sequencer #(
  parameter int WORD_SIZE    = 16,
  parameter int INPUT_LENGTH = 8,
  parameter int ADDR_WIDTH   = $clog2(INPUT_LENGTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WORD_SIZE-1:0]  data_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [WORD_SIZE-1:0]  mem_data_i,
  output logic [WORD_SIZE-1:0]  lu_mem_o,
  output logic [WORD_SIZE-1:0]  lu_data_o,
  output logic                  lu_sum_en_o,
  output logic                  lu_add_bias_o,
  output logic                  lu_clear_o,
  input  logic [WORD_SIZE-1:0]  lu_result_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_SIZE-1:0]  data_o
);

`ifdef MAC_SEQUENCER_BIAS_EN
  typedef enum logic [2:0] {S_CLEAR, S_ACCUM, S_BIAS, S_BIAS_APPLY, S_OUTPUT} state_e;
`else
  typedef enum logic [2:0] {S_CLEAR, S_ACCUM, S_DRAIN, S_OUTPUT} state_e;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(INPUT_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BIAS_ADDR = ADDR_WIDTH'(INPUT_LENGTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]  data_q, data_d;
  logic                  issue_q, issue_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      data_q  <= '0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      issue_q <= issue_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    issue_d       = 1'b0;
    ready_o       = 1'b0;
    mem_addr_o    = '0;
    lu_clear_o    = 1'b0;
    lu_add_bias_o = 1'b0;
    valid_o       = 1'b0;
    data_o        = '0;
    // A beat accepted last cycle meets its weight now: the ROM answers one cycle after the address.
    lu_sum_en_o   = issue_q;
    lu_data_o     = issue_q ? data_q : '0;
    lu_mem_o      = issue_q ? mem_data_i : '0;

    case (state_q)
      S_CLEAR: begin
        lu_clear_o = 1'b1;
        cnt_d      = '0;
        state_d    = S_ACCUM;
      end
      S_ACCUM: begin
        ready_o    = 1'b1;
        mem_addr_o = cnt_q;
        if (valid_i) begin
          data_d  = data_i;
          issue_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
`ifdef MAC_SEQUENCER_BIAS_EN
            state_d = S_BIAS;
`else
            state_d = S_DRAIN;
`endif
          end
        end
      end
`ifdef MAC_SEQUENCER_BIAS_EN
      S_BIAS: begin
        mem_addr_o = BIAS_ADDR;
        state_d    = S_BIAS_APPLY;
      end
      S_BIAS_APPLY: begin
        lu_sum_en_o   = 1'b1;
        lu_add_bias_o = 1'b1;
        lu_mem_o      = mem_data_i;
        lu_data_o     = '0;
        state_d       = S_OUTPUT;
      end
`else
      S_DRAIN: begin
        state_d = S_OUTPUT;
      end
`endif
      S_OUTPUT: begin
        valid_o     = 1'b1;
        data_o      = lu_result_i;
        lu_sum_en_o = 1'b0;
        if (ready_i) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a ROM and a Q4.12 saturating logical_unit model; results checked via a scoreboard.
module tb_mac_sequencer;
  localparam int WS = 16;
  localparam int IL = 4;
  localparam int AW = $clog2(IL + 1);
`ifdef MAC_SEQUENCER_BIAS_EN
  localparam int LAT   = 3;
  localparam int NBIAS = 1;
`else
  localparam int LAT   = 2;
  localparam int NBIAS = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_i, valid_i, ready_o, ready_i, valid_o;
  logic          lu_sum_en, lu_add_bias, lu_clear;
  logic [WS-1:0] data_i, lu_mem, lu_data, lu_result, data_o;
  logic [WS-1:0] mem_data_i = '0;
  logic [AW-1:0] mem_addr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sum_en_tot = 0, bias_tot = 0, clear_tot = 0;
  int sum_en_cyc[$];
  logic [WS-1:0] sb[$];

  mac_sequencer #(.WORD_SIZE(WS), .INPUT_LENGTH(IL)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data_i), .lu_mem_o(lu_mem), .lu_data_o(lu_data),
    .lu_sum_en_o(lu_sum_en), .lu_add_bias_o(lu_add_bias), .lu_clear_o(lu_clear),
    .lu_result_i(lu_result), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WS-1:0] sat16(input logic signed [39:0] a);
    if (a > 40'sd32767) return 16'h7FFF;
    else if (a < -40'sd32768) return 16'h8000;
    else return a[15:0];
  endfunction

  // ROM: weights 1.0 (Q4.12), bias 0.5, one-cycle read latency
  always @(posedge clk) mem_data_i <= (int'(mem_addr) < IL) ? 16'h1000 : 16'h0800;

  // logical_unit model
  logic signed [39:0] acc = '0;
  logic signed [39:0] lu_m, lu_d;
  assign lu_m = $signed(lu_mem);
  assign lu_d = $signed(lu_data);
  assign lu_result = sat16(acc);
  always @(posedge clk) begin
    if (lu_clear) acc <= '0;
    else if (lu_sum_en) acc <= lu_add_bias ? acc + lu_m : acc + ((lu_m * lu_d) >>> 12);
  end

  always @(posedge clk) begin
    if (!reset_i) begin
      if (lu_sum_en) begin
        sum_en_tot++;
        sum_en_cyc.push_back(cyc);
      end
      if (lu_add_bias) bias_tot++;
      if (lu_clear) clear_tot++;
    end
  end

  function automatic logic [WS-1:0] ref_result(input logic [WS-1:0] w);
    logic signed [39:0] a, x, k;
    a = '0;
    x = $signed(w);
    k = 40'sh1000;
    for (int i = 0; i < IL; i++) a = a + ((x * k) >>> 12);
`ifdef MAC_SEQUENCER_BIAS_EN
    a = a + 40'sh800;
`endif
    return sat16(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_vector(input logic [WS-1:0] w, input int gap_len, input int nbeats,
                             output int last_acc);
    last_acc = 0;
    for (int b = 0; b < nbeats; b++) begin
      int guard = 0;
      if (b == 2 && gap_len > 0) begin
        valid_i = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      valid_i = 1'b1;
      data_i  = w;
      while (!ready_o && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("accept_beat%0d", b), ready_o, 1);
      check($sformatf("addr_beat%0d", b), mem_addr, b);
      last_acc = cyc;
      @(negedge clk);
    end
    valid_i = 1'b0;
  endtask

  task automatic get_output(input int last_acc, input int stall);
    int guard = 0;
    int clr0;
    logic [WS-1:0] expv;
    ready_i = (stall == 0);
    while (!valid_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("latency", cyc - last_acc, LAT);
    if (sb.size() > 0) expv = sb.pop_front();
    else begin
      expv = 'x;
      check("scoreboard_nonempty", 0, 1);
    end
    clr0 = clear_tot;
    for (int s = 0; s < stall; s++) begin
      check("hold_valid", valid_o, 1);
      check("hold_data", data_o, expv);
      check("hold_ready_o", ready_o, 0);
      @(negedge clk);
    end
    ready_i = 1'b1;
    check("result", data_o, expv);
    check("result_valid", valid_o, 1);
    @(negedge clk);
    check("clear_after_hs", lu_clear, 1);
    check("valid_drop", valid_o, 0);
    @(negedge clk);
    check("clear_single", lu_clear, 0);
    check("clear_count", clear_tot - clr0, 1);
  endtask

  task automatic check_tail();
`ifdef MAC_SEQUENCER_BIAS_EN
    check("bias_addr", mem_addr, IL);
`endif
    check("tail_ready_o", ready_o, 0);
    check("tail_add_bias0", lu_add_bias, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int la, s0, b0, i0;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready_o", ready_o, 0);
    check("rst_valid_o", valid_o, 0);
    check("rst_clear", lu_clear, 1);
    check("rst_sum_en", lu_sum_en, 0);
    check("rst_data_o", data_o, 0);
    reset_i = 1'b0;
    check("first_clear", lu_clear, 1);

    // back-to-back vector
    sb.push_back(ref_result(16'h1000));
    s0 = sum_en_tot; b0 = bias_tot; i0 = sum_en_cyc.size();
    send_vector(16'h1000, 0, IL, la);
    check_tail();
    get_output(la, 0);
    check("sum_en_count", sum_en_tot - s0, IL + NBIAS);
    check("add_bias_count", bias_tot - b0, NBIAS);
    check("sum_en_spacing", sum_en_cyc[i0+2] - sum_en_cyc[i0+1], 1);

    // two idle cycles between beats 1 and 2
    sb.push_back(ref_result(16'h1000));
    s0 = sum_en_tot; b0 = bias_tot; i0 = sum_en_cyc.size();
    send_vector(16'h1000, 2, IL, la);
    check_tail();
    get_output(la, 0);
    check("gap_sum_en_count", sum_en_tot - s0, IL + NBIAS);
    check("gap_add_bias_count", bias_tot - b0, NBIAS);
    check("gap_spacing", sum_en_cyc[i0+2] - sum_en_cyc[i0+1], 3);

    // downstream stall of 5 cycles
    sb.push_back(ref_result(16'h1000));
    send_vector(16'h1000, 0, IL, la);
    get_output(la, 5);

    // reset mid-vector, then a saturating vector
    send_vector(16'h1000, 0, 2, la);
    #2 reset_i = 1'b1;
    #1;
    check("mid_rst_ready_o", ready_o, 0);
    check("mid_rst_valid_o", valid_o, 0);
    check("mid_rst_sum_en", lu_sum_en, 0);
    check("mid_rst_add_bias", lu_add_bias, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_data_o", data_o, 0);
    check("mid_rst_lu_mem", lu_mem, 0);
    check("mid_rst_lu_data", lu_data, 0);
    check("mid_rst_clear", lu_clear, 1);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    check("post_rst_clear", lu_clear, 1);
    check("post_rst_ready_o", ready_o, 0);
    sb.push_back(ref_result(16'h2000));
    s0 = sum_en_tot;
    send_vector(16'h2000, 0, IL, la);
    check_tail();
    get_output(la, 0);
    check("sat_sum_en_count", sum_en_tot - s0, IL + NBIAS);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
